// File: rtl/pop_sequencer.sv
// pop_sequencer: runtime-programmable multi-channel pulse sequencer with start/abort, finite or continuous repeat and status outputs.
//   clk, reset       system clock, synchronous active-high reset
//   start, abort     run control (start honoured only when idle, abort wins)
//   period           cycle length in ticks (>= 2)
//   t_on, t_off      per-channel rising/falling edge times, WIDTH bits each
//   repeats          cycles per run, 0 = continuous
//   ch_out           registered channel outputs
//   busy             high while running
//   cycle_start      high on every running tick with count == 0
//   done             one-tick pulse after a finite run completes
//   err              one-tick pulse when a start is rejected for period < 2
//   cycles           completed-cycle count of the current or last run
module pop_sequencer #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int REP_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     period,
    input  logic [NCH*WIDTH-1:0] t_on,
    input  logic [NCH*WIDTH-1:0] t_off,
    input  logic [REP_W-1:0]     repeats,
    output logic [NCH-1:0]       ch_out,
    output logic                 busy,
    output logic                 cycle_start,
    output logic                 done,
    output logic                 err,
    output logic [REP_W-1:0]     cycles
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] count, sh_per, cnt_n;
    logic [NCH*WIDTH-1:0] sh_on, sh_off, on_src, off_src;
    logic [REP_W-1:0] sh_rep;
    logic [REP_W:0] cyc_inc;
    logic [NCH-1:0] ch_n;
    logic go, rej, wrap, last, stop;
    assign cyc_inc = {1'b0, cycles} + 1'b1;
    assign go   = state == IDLE && start && !abort && period >= WIDTH'(2);
    assign rej  = state == IDLE && start && !abort && period < WIDTH'(2);
    // sh_per >= 2 whenever running, so the decrement cannot underflow
    assign wrap = state == RUN && !abort && count == sh_per - WIDTH'(1);
    assign last = wrap && sh_rep != '0 && cyc_inc == {1'b0, sh_rep};
    assign stop = state == RUN && (abort || (wrap && (last || period < WIDTH'(2))));
    // On a load the new edge times apply to count 0 of the coming cycle
    assign on_src  = (go || wrap) ? t_on  : sh_on;
    assign off_src = (go || wrap) ? t_off : sh_off;
    assign cnt_n   = (go || wrap) ? '0 : count + WIDTH'(1);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ch_n[i] = cnt_n >= on_src[i*WIDTH +: WIDTH] && cnt_n < off_src[i*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (go) state_n = RUN;
        else if (stop) state_n = IDLE;
    end
    always_comb begin
        busy        = state == RUN;
        cycle_start = state == RUN && count == '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            sh_per <= '0;
            sh_on  <= '0;
            sh_off <= '0;
            sh_rep <= '0;
            cycles <= '0;
            ch_out <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            count  <= state_n == RUN ? cnt_n : '0;
            ch_out <= state_n == RUN ? ch_n : '0;
            done   <= last;
            err    <= rej;
            if (go || wrap) begin
                sh_per <= period;
                sh_on  <= t_on;
                sh_off <= t_off;
            end
            if (go) begin
                sh_rep <= repeats;
                cycles <= '0;
            end else if (wrap && !cyc_inc[REP_W]) begin
                cycles <= cyc_inc[REP_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_pop_sequencer.sv
// tb_pop_sequencer: directed bench with a tick-level behavioural model checked every cycle plus literal expectations.
module tb_pop_sequencer;
    localparam int W = 16, N = 4, R = 8;
    logic clk = 0, reset = 1, start = 0, abort = 0;
    logic [W-1:0] period = 0;
    logic [N*W-1:0] t_on = 0, t_off = 0;
    logic [R-1:0] repeats = 0;
    logic [N-1:0] ch_out;
    logic busy, cycle_start, done, err;
    logic [R-1:0] cycles;
    int checks = 0, failures = 0;
    bit cmp_en = 0;

    pop_sequencer #(.WIDTH(W), .NCH(N), .REP_W(R)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .period(period),
        .t_on(t_on), .t_off(t_off), .repeats(repeats), .ch_out(ch_out), .busy(busy),
        .cycle_start(cycle_start), .done(done), .err(err), .cycles(cycles));

    always #5 clk = ~clk;

    // Model state: whether running, position in cycle, completed cycles, latched settings
    bit m_run, m_done, m_err;
    int m_cnt, m_n, m_per, m_rep;
    int m_on[N], m_off[N];

    task automatic latch_edges();
        m_per = period;
        for (int i = 0; i < N; i++) begin
            m_on[i]  = t_on[i*W +: W];
            m_off[i] = t_off[i*W +: W];
        end
    endtask

    always @(posedge clk) begin
        m_done = 0;
        m_err  = 0;
        if (reset) begin
            m_run = 0; m_cnt = 0; m_n = 0; m_per = 0; m_rep = 0;
            for (int i = 0; i < N; i++) begin m_on[i] = 0; m_off[i] = 0; end
        end else if (!m_run) begin
            if (start && !abort) begin
                if (period >= 2) begin
                    m_run = 1; m_cnt = 0; m_n = 0; m_rep = repeats;
                    latch_edges();
                end else m_err = 1;
            end
        end else if (abort) begin
            m_run = 0;
        end else if (m_cnt == m_per - 1) begin
            m_n++;
            latch_edges();
            if (m_rep != 0 && m_n == m_rep) begin m_run = 0; m_done = 1; end
            else if (m_per < 2) m_run = 0;
            else m_cnt = 0;
        end else m_cnt++;
    end

    function automatic logic [N-1:0] model_ch();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_run && m_cnt >= m_on[i] && m_cnt < m_off[i];
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (cmp_en) begin
        chk("model ch_out", int'(ch_out), int'(model_ch()));
        chk("model busy", int'(busy), int'(m_run));
        chk("model cycle_start", int'(cycle_start), int'(m_run && m_cnt == 0));
        chk("model done", int'(done), int'(m_done));
        chk("model err", int'(err), int'(m_err));
        chk("model cycles", int'(cycles), m_n > 255 ? 255 : m_n);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(int i, int on, int off);
        t_on[i*W +: W]  = W'(on);
        t_off[i*W +: W] = W'(off);
    endtask

    task automatic clear_ch();
        t_on = '0;
        t_off = '0;
    endtask

    task automatic stop_run();
        abort = 1; step(); abort = 0; step();
    endtask

    task automatic run_t1(string tag);
        clear_ch(); set_ch(0, 2, 5); period = 10; repeats = 2; start = 1;
        for (int k = 1; k <= 23; k++) begin
            step(); start = 0;
            case (k)
                1: begin chk({tag, " busy@1"}, busy, 1); chk({tag, " cs@1"}, cycle_start, 1); end
                2: chk({tag, " ch0@2"}, ch_out[0], 0);
                3: chk({tag, " ch0@3"}, ch_out[0], 1);
                5: chk({tag, " ch0@5"}, ch_out[0], 1);
                6: chk({tag, " ch0@6"}, ch_out[0], 0);
                11: chk({tag, " cs@11"}, cycle_start, 1);
                13: chk({tag, " ch0@13"}, ch_out[0], 1);
                16: chk({tag, " ch0@16"}, ch_out[0], 0);
                20: begin chk({tag, " busy@20"}, busy, 1); chk({tag, " done@20"}, done, 0); end
                21: begin chk({tag, " done@21"}, done, 1); chk({tag, " busy@21"}, busy, 0); chk({tag, " cycles@21"}, cycles, 2); end
                22: begin chk({tag, " done@22"}, done, 0); chk({tag, " cycles@22"}, cycles, 2); end
                default: ;
            endcase
        end
    endtask

    initial begin
        step(); step();
        reset = 0; cmp_en = 1;
        chk("reset ch_out", ch_out, 0); chk("reset busy", busy, 0); chk("reset cycles", cycles, 0);
        chk("reset done", done, 0); chk("reset err", err, 0); chk("reset cs", cycle_start, 0);

        run_t1("t1");

        clear_ch(); set_ch(0, 1, 3); period = 8; repeats = 0; start = 1;
        for (int k = 1; k <= 33; k++) begin
            step(); start = 0;
            if (k == 29) chk("t2 busy@29", busy, 1);
            if (k == 30) abort = 1;
            if (k == 31) begin
                abort = 0;
                chk("t2 busy@31", busy, 0); chk("t2 ch@31", ch_out, 0);
                chk("t2 done@31", done, 0); chk("t2 cycles@31", cycles, 3);
            end
        end

        clear_ch(); set_ch(1, 6, 4); set_ch(2, 0, 12); period = 10; repeats = 1; start = 1;
        for (int k = 1; k <= 12; k++) begin
            step(); start = 0;
            if (k == 1) chk("t3 ch2@1", ch_out[2], 1);
            if (k == 7) chk("t3 ch1@7", ch_out[1], 0);
            if (k == 10) chk("t3 ch2@10", ch_out[2], 1);
            if (k == 11) begin chk("t3 done@11", done, 1); chk("t3 ch@11", ch_out, 0); end
        end

        clear_ch(); period = 1; repeats = 0; start = 1;
        step(); start = 0;
        chk("t4 err@1", err, 1); chk("t4 busy@1", busy, 0);
        step(); chk("t4 err@2", err, 0);
        start = 1; abort = 1; step(); start = 0; abort = 0;
        chk("t4 start+abort busy", busy, 0); chk("t4 start+abort err", err, 0);
        period = 10; start = 1;
        for (int k = 1; k <= 5; k++) begin
            step(); start = 0;
            if (k == 3) start = 1;
            if (k == 4) begin chk("t4 restart err", err, 0); chk("t4 restart busy", busy, 1); chk("t4 restart cs", cycle_start, 0); end
        end
        stop_run();

        clear_ch(); set_ch(0, 2, 5); period = 10; repeats = 0; start = 1;
        for (int k = 1; k <= 20; k++) begin
            step(); start = 0;
            if (k == 3) chk("t5 ch0@3", ch_out[0], 1);
            if (k == 4) set_ch(0, 7, 5);
            if (k == 13) chk("t5 ch0@13", ch_out[0], 0);
            if (k == 14) set_ch(0, 7, 9);
            if (k == 18) chk("t5 ch0@18", ch_out[0], 0);
        end
        stop_run();

        clear_ch(); set_ch(0, 7, 9); period = 10; repeats = 0; start = 1;
        for (int k = 1; k <= 9; k++) begin step(); start = 0; end
        chk("t5b ch0@9", ch_out[0], 1);
        stop_run();

        clear_ch(); set_ch(0, 2, 5); period = 10; repeats = 2; start = 1;
        for (int k = 1; k <= 3; k++) begin step(); start = 0; end
        chk("t6 ch0 before reset", ch_out[0], 1);
        reset = 1; step(); reset = 0;
        chk("t6 ch after reset", ch_out, 0); chk("t6 busy after reset", busy, 0);
        chk("t6 cycles after reset", cycles, 0);
        step();
        run_t1("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
